axil_spi_bridge: RTL

AXI4-Lite slave that converts single-beat register accesses into byte transactions for the SPI master in the spi2axi path. It drives the master's start pulses, address, opcode and write byte, and returns the captured read byte as AXI read data. It also holds a small CSR set: the SPI clock divider and the write/read opcodes. It sits directly upstream of SPI_Master.

---
 rtl/spi2axi_pkg.sv | 39 +++
 rtl/axil_spi_bridge_wr_latch.sv | 60 ++++++
 rtl/axil_spi_bridge.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi2axi_pkg.sv
// Shared types and constants for the AXI4-Lite to SPI bridge.
package spi2axi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CSR,
      ST_SPI_START,
      ST_SPI_WAIT,
      ST_DRAIN,
      ST_RESP_B,
      ST_RESP_R
   } state_t;

   typedef enum logic [1:0] {
      K_SPI,
      K_CTRL,
      K_STATUS,
      K_ERR
   } kind_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [9:0] CTRL_OFS   = 10'h000;
   localparam logic [9:0] STATUS_OFS = 10'h004;

   // CTRL is {rd_op, wr_op, divider}; each byte lane is written only when its strobe is set.
   function automatic logic [23:0] ctrl_merge(input logic [23:0] cur,
                                              input logic [23:0] wd,
                                              input logic [2:0]  strb);
      logic [23:0] res;
      res = cur;
      for (int unsigned i = 0; i < 3; i++) begin
         if (strb[i]) res[i*8 +: 8] = wd[i*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/axil_spi_bridge_wr_latch.sv
// Independent AW / W capture for the bridge; a write is pending once both halves are held.
module axil_wr_latch #(
   parameter int ADDR_W = 12
) (
   input  logic              sclk,
   input  logic              srstn,
   input  logic              idle_i,
   input  logic              take_i,
   input  logic [ADDR_W-1:0] awaddr_i,
   input  logic              awvalid_i,
   output logic              awready_o,
   input  logic [31:0]       wdata_i,
   input  logic [3:0]        wstrb_i,
   input  logic              wvalid_i,
   output logic              wready_o,
   output logic              req_o,
   output logic              pending_o,
   output logic [ADDR_W-1:0] awaddr_o,
   output logic [31:0]       wdata_o,
   output logic [3:0]        wstrb_o
);

   logic              aw_q, w_q;
   logic [ADDR_W-1:0] awaddr_q;
   logic [31:0]       wdata_q;
   logic [3:0]        wstrb_q;

   assign awready_o = idle_i & ~aw_q;
   assign wready_o  = idle_i & ~w_q;
   assign pending_o = aw_q & w_q;
   // Write is pending now or completes at this edge; used to block a competing read.
   assign req_o     = (aw_q | (awvalid_i & awready_o)) & (w_q | (wvalid_i & wready_o));
   assign awaddr_o  = awaddr_q;
   assign wdata_o   = wdata_q;
   assign wstrb_o   = wstrb_q;

   always_ff @(posedge sclk) begin
      if (!srstn) begin
         aw_q     <= 1'b0;
         w_q      <= 1'b0;
         awaddr_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
      end else if (take_i) begin
         aw_q <= 1'b0;
         w_q  <= 1'b0;
      end else begin
         if (awvalid_i && awready_o) begin
            aw_q     <= 1'b1;
            awaddr_q <= awaddr_i;
         end
         if (wvalid_i && wready_o) begin
            w_q     <= 1'b1;
            wdata_q <= wdata_i;
            wstrb_q <= wstrb_i;
         end
      end
   end

endmodule

// File: rtl/axil_spi_bridge.sv
// AXI4-Lite slave turning single-beat accesses into SPI master byte transactions, plus CTRL/STATUS CSRs.
// Optional watchdog on SPI completion: define SPI_TIMEOUT_EN.
module axil_spi_bridge
   import spi2axi_pkg::*;
#(
   parameter int         ADDR_W         = 12,
   parameter logic [7:0] DIV_RST        = 8'd4,
   parameter logic [7:0] WR_OP_RST      = 8'h02,
   parameter logic [7:0] RD_OP_RST      = 8'h03,
   parameter int         TIMEOUT_CYCLES = 65535
) (
   input  logic              sclk,
   input  logic              srstn,
   input  logic [ADDR_W-1:0] s_awaddr,
   input  logic              s_awvalid,
   output logic              s_awready,
   input  logic [31:0]       s_wdata,
   input  logic [3:0]        s_wstrb,
   input  logic              s_wvalid,
   output logic              s_wready,
   output logic [1:0]        s_bresp,
   output logic              s_bvalid,
   input  logic              s_bready,
   input  logic [ADDR_W-1:0] s_araddr,
   input  logic              s_arvalid,
   output logic              s_arready,
   output logic [31:0]       s_rdata,
   output logic [1:0]        s_rresp,
   output logic              s_rvalid,
   input  logic              s_rready,
   output logic [7:0]        spi_sclk_divider,
   output logic              spi_wr_start,
   output logic              spi_rd_start,
   output logic [7:0]        spi_start_addr,
   output logic [7:0]        spi_state_init,
   output logic [7:0]        spi_wr_byte,
   input  logic [7:0]        spi_rd_byte,
   input  logic              spi_wr_finish,
   input  logic              spi_rd_finish
);

   state_t      state_q;
   kind_t       kind_q;
   logic        dir_wr_q, last_rd_q, drain_q;
   logic [7:0]  div_q, wrop_q, rdop_q, last_byte_q;
   logic        bvalid_q, rvalid_q, wr_start_q, rd_start_q;
   logic [1:0]  bresp_q, rresp_q;
   logic [31:0] rdata_q;
   logic [7:0]  start_addr_q, state_init_q, wr_byte_q;

   logic              idle, wr_req, wr_pending, wr_take, rd_take;
   logic [ADDR_W-1:0] awaddr_l;
   logic [31:0]       wdata_l;
   logic [3:0]        wstrb_l;
   kind_t             aw_kind, ar_kind;
   logic              unused_bits;

`ifdef SPI_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q;
`else
   assign drain_q = 1'b0;
`endif

   function automatic kind_t decode(input logic [ADDR_W-1:0] a);
      if ((a >> 11) != '0) return K_ERR;
      if (!a[10]) return K_SPI;
      if ({a[9:2], 2'b00} == CTRL_OFS) return K_CTRL;
      if ({a[9:2], 2'b00} == STATUS_OFS) return K_STATUS;
      return K_ERR;
   endfunction

   axil_wr_latch #(.ADDR_W(ADDR_W)) u_wr_latch (
      .sclk      (sclk),
      .srstn     (srstn),
      .idle_i    (idle),
      .take_i    (wr_take),
      .awaddr_i  (s_awaddr),
      .awvalid_i (s_awvalid),
      .awready_o (s_awready),
      .wdata_i   (s_wdata),
      .wstrb_i   (s_wstrb),
      .wvalid_i  (s_wvalid),
      .wready_o  (s_wready),
      .req_o     (wr_req),
      .pending_o (wr_pending),
      .awaddr_o  (awaddr_l),
      .wdata_o   (wdata_l),
      .wstrb_o   (wstrb_l)
   );

   assign idle      = (state_q == ST_IDLE);
   // Round-robin: a write beats a read only when the read class was served last.
   assign s_arready = idle & ~(wr_req & last_rd_q);
   assign wr_take   = idle & wr_pending & (last_rd_q | ~s_arvalid);
   assign rd_take   = s_arvalid & s_arready;
   assign aw_kind   = decode(awaddr_l);
   assign ar_kind   = decode(s_araddr);
   assign unused_bits = ^{wdata_l[31:24], wstrb_l[3]};

   assign s_bvalid         = bvalid_q;
   assign s_bresp          = bresp_q;
   assign s_rvalid         = rvalid_q;
   assign s_rresp          = rresp_q;
   assign s_rdata          = rdata_q;
   assign spi_sclk_divider = div_q;
   assign spi_wr_start     = wr_start_q;
   assign spi_rd_start     = rd_start_q;
   assign spi_start_addr   = start_addr_q;
   assign spi_state_init   = state_init_q;
   assign spi_wr_byte      = wr_byte_q;

   always_ff @(posedge sclk) begin
      if (!srstn) begin
         state_q      <= ST_IDLE;
         kind_q       <= K_SPI;
         dir_wr_q     <= 1'b0;
         last_rd_q    <= 1'b1;
         div_q        <= DIV_RST;
         wrop_q       <= WR_OP_RST;
         rdop_q       <= RD_OP_RST;
         last_byte_q  <= '0;
         bvalid_q     <= 1'b0;
         rvalid_q     <= 1'b0;
         bresp_q      <= RESP_OKAY;
         rresp_q      <= RESP_OKAY;
         rdata_q      <= '0;
         wr_start_q   <= 1'b0;
         rd_start_q   <= 1'b0;
         start_addr_q <= '0;
         state_init_q <= '0;
         wr_byte_q    <= '0;
`ifdef SPI_TIMEOUT_EN
         cnt_q        <= '0;
         drain_q      <= 1'b0;
`endif
      end else begin
         wr_start_q <= 1'b0;
         rd_start_q <= 1'b0;
`ifdef SPI_TIMEOUT_EN
         if (drain_q && (dir_wr_q ? spi_wr_finish : spi_rd_finish)) drain_q <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               if (wr_take) begin
                  dir_wr_q  <= 1'b1;
                  last_rd_q <= 1'b0;
                  kind_q    <= aw_kind;
                  if (aw_kind == K_SPI) begin
                     start_addr_q <= awaddr_l[9:2];
                     state_init_q <= wrop_q;
                     wr_byte_q    <= wstrb_l[0] ? wdata_l[7:0] : 8'h00;
                     wr_start_q   <= 1'b1;
                     state_q      <= ST_SPI_START;
                  end else begin
                     state_q <= ST_CSR;
                  end
               end else if (rd_take) begin
                  dir_wr_q  <= 1'b0;
                  last_rd_q <= 1'b1;
                  kind_q    <= ar_kind;
                  if (ar_kind == K_SPI) begin
                     start_addr_q <= s_araddr[9:2];
                     state_init_q <= rdop_q;
                     rd_start_q   <= 1'b1;
                     state_q      <= ST_SPI_START;
                  end else begin
                     state_q <= ST_CSR;
                  end
               end
            end
            ST_CSR: begin
               if (dir_wr_q) begin
                  if (kind_q == K_CTRL)
                     {rdop_q, wrop_q, div_q} <= ctrl_merge({rdop_q, wrop_q, div_q},
                                                           wdata_l[23:0], wstrb_l[2:0]);
                  bresp_q  <= (kind_q == K_ERR) ? RESP_SLVERR : RESP_OKAY;
                  bvalid_q <= 1'b1;
                  state_q  <= ST_RESP_B;
               end else begin
                  case (kind_q)
                     K_CTRL:   rdata_q <= {8'h00, rdop_q, wrop_q, div_q};
                     K_STATUS: rdata_q <= {16'h0000, last_byte_q, 7'h00, drain_q};
                     default:  rdata_q <= '0;
                  endcase
                  rresp_q  <= (kind_q == K_ERR) ? RESP_SLVERR : RESP_OKAY;
                  rvalid_q <= 1'b1;
                  state_q  <= ST_RESP_R;
               end
            end
            ST_SPI_START: begin
               state_q <= ST_SPI_WAIT;
`ifdef SPI_TIMEOUT_EN
               cnt_q   <= '0;
`endif
            end
            ST_SPI_WAIT: begin
               if (dir_wr_q && spi_wr_finish) begin
                  bresp_q  <= RESP_OKAY;
                  bvalid_q <= 1'b1;
                  state_q  <= ST_RESP_B;
               end else if (!dir_wr_q && spi_rd_finish) begin
                  rdata_q     <= {24'h000000, spi_rd_byte};
                  last_byte_q <= spi_rd_byte;
                  rresp_q     <= RESP_OKAY;
                  rvalid_q    <= 1'b1;
                  state_q     <= ST_RESP_R;
               end
`ifdef SPI_TIMEOUT_EN
               else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  drain_q <= 1'b1;
                  if (dir_wr_q) begin
                     bresp_q  <= RESP_SLVERR;
                     bvalid_q <= 1'b1;
                     state_q  <= ST_RESP_B;
                  end else begin
                     rdata_q  <= '0;
                     rresp_q  <= RESP_SLVERR;
                     rvalid_q <= 1'b1;
                     state_q  <= ST_RESP_R;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
`endif
            end
            ST_RESP_B: begin
               if (s_bready) begin
                  bvalid_q <= 1'b0;
                  state_q  <= drain_q ? ST_DRAIN : ST_IDLE;
               end
            end
            ST_RESP_R: begin
               if (s_rready) begin
                  rvalid_q <= 1'b0;
                  state_q  <= drain_q ? ST_DRAIN : ST_IDLE;
               end
            end
            ST_DRAIN: begin
               if (!drain_q) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
